// File: rtl/ex_issue_ctrl.sv
// ex_issue_ctrl: issue control between decode and execute.
// Handles the decode handshake, load-use stalls through a per-register
// scoreboard, operand-forwarding selects, and the taken-branch flush sequence.
module ex_issue_ctrl #(
   parameter int wd_regs_p   = 32,
   parameter int n_regs_p    = 32,
   parameter int max_ld_p    = 2,
   parameter int flush_cyc_p = 2,
   localparam int idx_w      = $clog2(n_regs_p)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_dec_valid,
   output logic             o_dec_ready,
   input  logic [idx_w-1:0] i_rs1,
   input  logic [idx_w-1:0] i_rs2,
   input  logic [idx_w-1:0] i_rd,
   input  logic             i_use_rs1,
   input  logic             i_use_rs2,
   input  logic             i_rd_we,
   input  logic             i_is_load,
   output logic             o_issue,
   output logic [1:0]       o_fwd1_sel,
   output logic [1:0]       o_fwd2_sel,
   input  logic             i_br_taken,
   output logic             o_flush,
   input  logic             i_ld_done,
   input  logic [idx_w-1:0] i_ld_rd,
   output logic             o_busy
);

   localparam int cnt_w = $clog2(max_ld_p + 1);

   // Parameter range guard; register width is only carried for consistency.
   if (wd_regs_p < 1 || max_ld_p < 1 || max_ld_p > 7 ||
       flush_cyc_p < 1 || flush_cyc_p > 15) begin : g_bad_param
      $error("ex_issue_ctrl: parameter out of range");
   end

   typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

   state_t             state, state_nx;
   logic [3:0]         fcnt, fcnt_nx;
   logic [n_regs_p-1:0] sb;
   logic [cnt_w-1:0]   ld_cnt;
   logic [idx_w-1:0]   ex_rd, wb_rd;
   logic               ex_we, wb_we;
   logic               hazard, ld_issue, ld_dec;

   // State register and flush counter
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= RUN;
         fcnt  <= '0;
      end else begin
         state <= state_nx;
         fcnt  <= fcnt_nx;
      end
   end

   // Next state: a taken branch in RUN starts the flush; a branch during FLUSH is ignored
   always_comb begin
      state_nx = state;
      fcnt_nx  = fcnt;
      case (state)
         RUN: begin
            if (i_br_taken) begin
               state_nx = FLUSH;
               fcnt_nx  = 4'(flush_cyc_p - 1);
            end
         end
         FLUSH: begin
            if (fcnt == 4'd0) state_nx = RUN;
            else              fcnt_nx  = fcnt - 4'd1;
         end
         default: state_nx = RUN;
      endcase
   end

   // Outputs: hazard detection, handshake, busy, forwarding selects
   always_comb begin
      hazard = (i_use_rs1 && i_rs1 != '0 && sb[i_rs1]) ||
               (i_use_rs2 && i_rs2 != '0 && sb[i_rs2]) ||
               (i_is_load && ld_cnt == cnt_w'(max_ld_p));
      o_flush     = (state == FLUSH);
      o_dec_ready = (state == RUN) && !i_br_taken && !hazard;
      o_issue     = i_dec_valid && o_dec_ready;
      o_busy      = (state != RUN) || (ld_cnt != '0);

      o_fwd1_sel = 2'd0;
      if (i_rs1 != '0) begin
         if (ex_we && ex_rd == i_rs1)      o_fwd1_sel = 2'd1;
         else if (wb_we && wb_rd == i_rs1) o_fwd1_sel = 2'd2;
      end
      o_fwd2_sel = 2'd0;
      if (i_rs2 != '0) begin
         if (ex_we && ex_rd == i_rs2)      o_fwd2_sel = 2'd1;
         else if (wb_we && wb_rd == i_rs2) o_fwd2_sel = 2'd2;
      end
   end

   assign ld_issue = o_issue && i_is_load;
   // A completion with nothing outstanding is dropped rather than underflowing.
   assign ld_dec   = i_ld_done && (ld_cnt != '0);

   // Scoreboard: clear on load completion, set on load issue; set is written last so it wins
   always_ff @(posedge clk) begin
      if (rst) begin
         sb <= '0;
      end else begin
         if (i_ld_done) sb[i_ld_rd] <= 1'b0;
         if (ld_issue && i_rd_we && i_rd != '0) sb[i_rd] <= 1'b1;
      end
   end

   // Outstanding-load counter; hazard blocks issue at the limit so it cannot overflow
   always_ff @(posedge clk) begin
      if (rst)                   ld_cnt <= '0;
      else if (ld_issue && !ld_dec) ld_cnt <= ld_cnt + 1'b1;
      else if (!ld_issue && ld_dec) ld_cnt <= ld_cnt - 1'b1;
   end

   // EX/WB destination tracking; loads and x0 never forward. No issue happens
   // in the branch cycle or during FLUSH, so the EX slot empties on a flush.
   always_ff @(posedge clk) begin
      if (rst) begin
         ex_rd <= '0;
         ex_we <= 1'b0;
         wb_rd <= '0;
         wb_we <= 1'b0;
      end else begin
         ex_rd <= i_rd;
         ex_we <= o_issue && i_rd_we && !i_is_load && (i_rd != '0);
         wb_rd <= ex_rd;
         wb_we <= ex_we;
      end
   end

endmodule

// File: tb/tb_ex_issue_ctrl.sv
// Directed bench for ex_issue_ctrl (defaults: 32 regs, 2 loads, 2 flush cycles).
module tb_ex_issue_ctrl;
   localparam int IW = 5;

   logic          clk = 1'b0;
   logic          rst;
   logic          i_dec_valid, o_dec_ready;
   logic [IW-1:0] i_rs1, i_rs2, i_rd, i_ld_rd;
   logic          i_use_rs1, i_use_rs2, i_rd_we, i_is_load;
   logic          o_issue, i_br_taken, o_flush, i_ld_done, o_busy;
   logic [1:0]    o_fwd1_sel, o_fwd2_sel;

   int vectors = 0;
   int miscompares = 0;

   ex_issue_ctrl dut (
      .clk(clk), .rst(rst),
      .i_dec_valid(i_dec_valid), .o_dec_ready(o_dec_ready),
      .i_rs1(i_rs1), .i_rs2(i_rs2), .i_rd(i_rd),
      .i_use_rs1(i_use_rs1), .i_use_rs2(i_use_rs2),
      .i_rd_we(i_rd_we), .i_is_load(i_is_load),
      .o_issue(o_issue), .o_fwd1_sel(o_fwd1_sel), .o_fwd2_sel(o_fwd2_sel),
      .i_br_taken(i_br_taken), .o_flush(o_flush),
      .i_ld_done(i_ld_done), .i_ld_rd(i_ld_rd), .o_busy(o_busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; return just after the falling edge, away from the active edge.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   task automatic op(input logic v, input logic [IW-1:0] rs1, input logic u1,
                     input logic [IW-1:0] rs2, input logic u2,
                     input logic [IW-1:0] rd, input logic we, input logic ld);
      i_dec_valid = v; i_rs1 = rs1; i_use_rs1 = u1; i_rs2 = rs2; i_use_rs2 = u2;
      i_rd = rd; i_rd_we = we; i_is_load = ld;
      i_br_taken = 1'b0; i_ld_done = 1'b0; i_ld_rd = '0;
   endtask

   task automatic idle();
      op(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
   endtask

   initial begin
      rst = 1'b1;
      idle();
      tick(); tick();
      #1;
      chk("rst_flush", o_flush, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_issue", o_issue, 0);
      chk("rst_fwd1", o_fwd1_sel, 0);
      chk("rst_ready", o_dec_ready, 1);
      rst = 1'b0;
      tick();

      // Back-to-back ALU ops with EX then WB forwarding
      op(1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0); #1;
      chk("a_issue", o_issue, 1);
      chk("a_fwd1", o_fwd1_sel, 0);
      tick();
      op(1, 5'd5, 1, 5'd0, 0, 5'd6, 1, 0); #1;
      chk("b_issue", o_issue, 1);
      chk("b_fwd1_ex", o_fwd1_sel, 1);
      tick();
      op(1, 5'd6, 1, 5'd5, 1, 5'd8, 1, 0); #1;
      chk("c_issue", o_issue, 1);
      chk("c_fwd1_ex", o_fwd1_sel, 1);
      chk("c_fwd2_wb", o_fwd2_sel, 2);
      tick();
      idle(); tick();

      // Load-use stall released by load completion
      op(1, 5'd0, 0, 5'd0, 0, 5'd7, 1, 1); #1;
      chk("ld7_issue", o_issue, 1);
      tick();
      op(1, 5'd7, 1, 5'd0, 0, 5'd9, 1, 0); #1;
      chk("lu_ready0", o_dec_ready, 0);
      chk("lu_issue0", o_issue, 0);
      chk("lu_busy", o_busy, 1);
      chk("lu_nofwd_ld", o_fwd1_sel, 0);
      tick();
      i_ld_done = 1'b1; i_ld_rd = 5'd7; #1;
      chk("lu_ready_done_cyc", o_dec_ready, 0);
      tick();
      i_ld_done = 1'b0; #1;
      chk("lu_issue_after", o_issue, 1);
      chk("lu_busy_clr", o_busy, 0);
      tick();

      // x0: load to x0 never stalls a reader of x0
      op(1, 5'd0, 0, 5'd0, 0, 5'd0, 1, 1); #1;
      chk("x0_ld_issue", o_issue, 1);
      tick();
      op(1, 5'd0, 1, 5'd0, 1, 5'd3, 1, 0); #1;
      chk("x0_ready", o_dec_ready, 1);
      chk("x0_fwd1", o_fwd1_sel, 0);
      chk("x0_fwd2", o_fwd2_sel, 0);
      tick();
      idle(); i_ld_done = 1'b1; i_ld_rd = 5'd0;
      tick();

      // Branch with pending op; second branch during FLUSH is ignored
      op(1, 5'd1, 1, 5'd0, 0, 5'd10, 1, 0); i_br_taken = 1'b1; #1;
      chk("br_busy_pre", o_busy, 0);
      chk("br_ready", o_dec_ready, 0);
      chk("br_issue", o_issue, 0);
      chk("br_flush0", o_flush, 0);
      tick();
      i_br_taken = 1'b1; #1;
      chk("fl1_flush", o_flush, 1);
      chk("fl1_issue", o_issue, 0);
      chk("fl1_busy", o_busy, 1);
      tick();
      i_br_taken = 1'b0; #1;
      chk("fl2_flush", o_flush, 1);
      tick();
      #1;
      chk("fl3_flush", o_flush, 0);
      chk("fl3_issue", o_issue, 1);
      tick();

      // Outstanding-load limit
      op(1, 5'd0, 0, 5'd0, 0, 5'd11, 1, 1); #1;
      chk("lim_ld1", o_issue, 1);
      tick();
      op(1, 5'd0, 0, 5'd0, 0, 5'd12, 1, 1); #1;
      chk("lim_ld2", o_issue, 1);
      tick();
      op(1, 5'd0, 0, 5'd0, 0, 5'd13, 1, 1); #1;
      chk("lim_ld3_stall", o_dec_ready, 0);
      tick();
      i_ld_done = 1'b1; i_ld_rd = 5'd11; #1;
      chk("lim_ld3_stall_done", o_issue, 0);
      tick();
      i_ld_done = 1'b1; i_ld_rd = 5'd12; #1;
      chk("lim_ld3_issue", o_issue, 1);
      tick();
      op(1, 5'd0, 0, 5'd0, 0, 5'd14, 1, 1); #1;
      chk("lim_ld4_issue", o_issue, 1);
      tick();
      op(1, 5'd0, 0, 5'd0, 0, 5'd15, 1, 1); #1;
      chk("lim_ld5_stall", o_dec_ready, 0);
      chk("lim_busy", o_busy, 1);
      tick();

      // Reset in the middle of a flush with scoreboard bit 13 set
      idle(); i_br_taken = 1'b1;
      tick();
      #1;
      chk("rf_flush", o_flush, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      op(1, 5'd13, 1, 5'd0, 0, 5'd2, 1, 0); #1;
      chk("rf_flush_clr", o_flush, 0);
      chk("rf_busy_clr", o_busy, 0);
      chk("rf_dep_issue", o_issue, 1);
      tick();
      idle();
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
